icache_line_refill: RTL

//  Fills the single-line I-cache buffer from memory on a miss. Accepts a miss PC, issues one burst read for
//  the aligned line, assembles BEATS data beats, then publishes the line. Drives line_pc / pending_pc, the
//  per-line "current" and "in-flight" tags the fetch-side presence check compares the PC against.

---
 rtl/mmm_pkg.sv | 15 +
 rtl/icache_line_refill.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mmm_pkg.sv
// Shared fetch-side constants and the I-cache refill FSM state type.
package mmm_pkg;

    localparam int unsigned XLEN              = 32;
    localparam int unsigned ICACHE_OFFSET     = 4;
    localparam int unsigned ICACHE_LINE_BYTES = 1 << ICACHE_OFFSET;

    typedef enum logic [1:0] {
        RF_IDLE,
        RF_ADDR,
        RF_DATA,
        RF_DRAIN
    } refill_state_t;

endpackage

// File: rtl/icache_line_refill.sv
// Single-line I-cache refill: one burst read per miss, assembles the line and publishes it.
// Optional `ICACHE_REFILL_PERF_EN adds refill_cnt_o / drop_cnt_o event counters.
module icache_line_refill
    import mmm_pkg::*;
#(
    parameter int unsigned BEAT_W = 32
) (
    input  logic                                            clk_i,
    input  logic                                            rst_i,
    input  logic                                            flush_i,
    input  logic                                            miss_valid_i,
    output logic                                            miss_ready_o,
    input  logic [XLEN-1:0]                                 miss_pc_i,
    output logic                                            mem_req_valid_o,
    input  logic                                            mem_req_ready_i,
    output logic [XLEN-1:0]                                 mem_addr_o,
    input  logic                                            mem_rsp_valid_i,
    input  logic [BEAT_W-1:0]                               mem_rsp_data_i,
    output logic                                            line_valid_o,
    output logic [XLEN-1:0]                                 line_pc_o,
    output logic [((ICACHE_LINE_BYTES*8)/BEAT_W)*BEAT_W-1:0] line_data_o,
    output logic                                            pending_o,
    output logic [XLEN-1:0]                                 pending_pc_o
`ifdef ICACHE_REFILL_PERF_EN
    ,
    output logic [31:0]                                     refill_cnt_o,
    output logic [31:0]                                     drop_cnt_o
`endif
);

    localparam int unsigned BEATS = (ICACHE_LINE_BYTES * 8) / BEAT_W;
    localparam int unsigned CNT_W = $clog2(BEATS);
    localparam int unsigned TAG_W = XLEN - ICACHE_OFFSET;

    refill_state_t    state;
    logic [CNT_W-1:0] cnt;
    logic [TAG_W-1:0] pending_tag;
    logic [TAG_W-1:0] line_tag;
    logic             last_beat;

    // Offset bits of the miss PC never reach any stored state.
    logic unused_offset;
    assign unused_offset = ^miss_pc_i[ICACHE_OFFSET-1:0];

    assign last_beat    = mem_rsp_valid_i && (cnt == CNT_W'(BEATS - 1));
    assign pending_pc_o = {pending_tag, {ICACHE_OFFSET{1'b0}}};
    assign line_pc_o    = {line_tag, {ICACHE_OFFSET{1'b0}}};
    assign mem_addr_o   = pending_pc_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= RF_IDLE;
            cnt             <= '0;
            pending_tag     <= '0;
            line_tag        <= '0;
            line_data_o     <= '0;
            line_valid_o    <= 1'b0;
            pending_o       <= 1'b0;
            mem_req_valid_o <= 1'b0;
            miss_ready_o    <= 1'b1;
        end else begin
            case (state)
                RF_IDLE: begin
                    if (flush_i) begin
                        line_valid_o <= 1'b0;
                    end else if (miss_valid_i) begin
                        pending_tag     <= miss_pc_i[XLEN-1:ICACHE_OFFSET];
                        pending_o       <= 1'b1;
                        line_valid_o    <= 1'b0;
                        mem_req_valid_o <= 1'b1;
                        miss_ready_o    <= 1'b0;
                        state           <= RF_ADDR;
                    end
                end
                RF_ADDR: begin
                    if (flush_i) begin
                        line_valid_o    <= 1'b0;
                        pending_o       <= 1'b0;
                        mem_req_valid_o <= 1'b0;
                        miss_ready_o    <= 1'b1;
                        state           <= RF_IDLE;
                    end else if (mem_req_ready_i) begin
                        mem_req_valid_o <= 1'b0;
                        state           <= RF_DATA;
                    end
                end
                RF_DATA: begin
                    if (flush_i) begin
                        // A beat coinciding with the flush still counts toward the burst,
                        // so the drain ends exactly when memory stops sending.
                        line_valid_o <= 1'b0;
                        pending_o    <= 1'b0;
                        if (last_beat) begin
                            cnt          <= '0;
                            miss_ready_o <= 1'b1;
                            state        <= RF_IDLE;
                        end else begin
                            cnt   <= cnt + CNT_W'(mem_rsp_valid_i);
                            state <= RF_DRAIN;
                        end
                    end else if (mem_rsp_valid_i) begin
                        line_data_o[cnt*BEAT_W +: BEAT_W] <= mem_rsp_data_i;
                        if (last_beat) begin
                            cnt          <= '0;
                            line_tag     <= pending_tag;
                            line_valid_o <= 1'b1;
                            pending_o    <= 1'b0;
                            miss_ready_o <= 1'b1;
                            state        <= RF_IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                RF_DRAIN: begin
                    if (mem_rsp_valid_i) begin
                        if (last_beat) begin
                            cnt          <= '0;
                            miss_ready_o <= 1'b1;
                            state        <= RF_IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= RF_IDLE;
            endcase
        end
    end

`ifdef ICACHE_REFILL_PERF_EN
    logic commit_evt;
    logic drop_evt;

    assign commit_evt = !flush_i && (state == RF_DATA) && last_beat;
    assign drop_evt   = flush_i && ((state == RF_ADDR) || (state == RF_DATA));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            refill_cnt_o <= '0;
            drop_cnt_o   <= '0;
        end else begin
            if (commit_evt) refill_cnt_o <= refill_cnt_o + 32'd1;
            if (drop_evt)   drop_cnt_o   <= drop_cnt_o + 32'd1;
        end
    end
`endif

endmodule
